zap_regf_write_scheduler: RTL and testbench
===========================================

# zap_regf_write_scheduler

Write-port scheduler for the ZAP dual-write-port register file (40 × 32 bits). It accepts writeback requests from three pipeline sources and maps up to two of them per cycle onto register-file write ports A and B. It resolves same-register collisions in program order and keeps the register file's per-entry copy-select bits coherent on idle cycles. After reset, it runs a clear sequence that zeroes all 40 entries before the first writeback is accepted.

## Interface
- NUM_REGS, 40: register-file depth; the highest index used is NUM_REGS-1.
- i_clk  in  1  core clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  3  per-source write request; source 0 is oldest in program order, source 2 youngest.
- i_req_addr0/1/2  in  6  destination register per source.
- i_req_data0/1/2  in  32  write data per source.
- o_req_ready  out  3  per-source grant; transfer occurs when valid & ready on the same edge.
- o_busy  out  1  clear sequence in progress.
- o_wen  out  1  to register-file write enable.
- o_wr_addr_a, o_wr_addr_b  out  6  to register-file write addresses.
- o_wr_data_a, o_wr_data_b  out  32  to register-file write data.

## Operation
- Register-file property the scheduler must honour: copy-select bits update every clock from both addresses, regardless of o_wen. On a same-address write, port B wins.
- States: CLEAR, RUN.
- CLEAR:
  - Entered on reset. o_busy=1, o_req_ready=0.
  - A 5-bit pair counter k runs from 0 to NUM_REGS/2-1.
  - Each cycle drives o_wen=1, addr_a=2k, addr_b=2k+1, data 0.
  - After k=NUM_REGS/2-1, go to RUN.
- RUN grant:
  - o_req_ready is combinational from i_req_valid.
  - Grant the two lowest-indexed valid sources. The third valid source sees ready=0 and must hold its request.
- RUN mapping:
  - Older granted request goes to port A, younger to port B.
  - If both granted addresses are equal, the younger request drives both ports (same addr, same data). Both sources are still granted; the older write is dropped.
  - A single granted request drives both ports with the same addr/data.
- RUN idle:
  - No grant: o_wen=0.
  - addr_a and addr_b re-present the previous cycle's addresses unchanged, so no select bit flips.
  - Data outputs hold.
- Addresses ≥ NUM_REGS are a source error. They are passed through unchecked, with a simulation-only assertion.

## Timing
- All outputs are registered except o_req_ready.
- Latency is 1 cycle: a request granted at edge N appears on o_wr_* / o_wen during cycle N..N+1 and is written into the register file at edge N+1.
- Data is readable from the register file combinationally after edge N+1.
- Reset values: o_wen=0, o_wr_addr_a=0, o_wr_addr_b=1, o_wr_data_a/b=0, o_busy=1, pair counter 0, state CLEAR.
- CLEAR lasts exactly NUM_REGS/2 cycles (20 at default). o_busy falls in the cycle the first RUN grant can occur.
- Reset asserted mid-CLEAR or mid-RUN restarts CLEAR from k=0 on the next edge. No grant is issued while reset is high.
- Three valid sources on the same cycle: sources 0 and 1 are granted, source 2 is stalled.
- Source 2 granted alone, or with one other source, follows the normal mapping; there is no starvation guarantee beyond program-order priority.

## Structure
- Shared package zap_regf_pkg: NUM_REGS, address width (6), state encoding (CLEAR=1'b0, RUN=1'b1).
- One natural sub-module, zap_regf_pick2: a combinational two-of-three oldest-first picker producing the grant vector and the older/younger source indices.
- Registered output stage and CLEAR FSM stay in the top module.

## Test plan
- Reset release: o_busy high for 20 cycles. Addresses (0,1),(2,3)…(38,39) with o_wen=1 and data 0. Ready stays 0 until o_busy falls.
- Single write: source 1 writes r5=0xDEAD_BEEF. Next cycle a=b=5, o_wen=1. Reading r5 after the edge returns 0xDEAD_BEEF.
- Dual write: source 0 writes r3=0x11, source 2 writes r7=0x22. Port A=(3,0x11), port B=(7,0x22). Both read back correctly.
- Collision: sources 0 and 1 both target r9 with 0xAA and 0xBB. Both ports carry (9,0xBB), both sources are granted, and r9 reads 0xBB.
- Overload: all three sources valid. Ready=3'b011. Source 2 is held, then written the next cycle with ready=3'b100.
- Idle coherency: dual write r2/r4, then 10 idle cycles. Addresses hold at (2,4), o_wen=0, and r2/r4 reads are unchanged. Assert reset mid-idle: CLEAR restarts at pair 0.

Source files
------------

// File: rtl/zap_regf_pkg.sv
// Shared constants and state encoding for the ZAP register-file write scheduler.
package zap_regf_pkg;

  localparam int NUM_REGS = 40;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int PAIR_W   = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  // Entry index of one half of a clear pair: even entry on port A, odd on port B.
  function automatic logic [ADDR_W-1:0] pair_addr(input logic [PAIR_W-1:0] k, input logic odd);
    return {k, odd};
  endfunction

endpackage

// File: rtl/zap_regf_write_scheduler_pick2.sv
// Combinational oldest-first picker: grants up to two of three requests and
// reports which granted source is older and which is younger.
module zap_regf_pick2 (
  input  logic [2:0] i_valid,
  output logic [2:0] o_grant,
  output logic [1:0] o_older,
  output logic [1:0] o_younger
);

  always_comb begin
    o_grant = i_valid;
    // Source 2 only loses when both older sources are asking.
    if (&i_valid) o_grant[2] = 1'b0;

    o_older = 2'd0;
    if (!i_valid[0]) o_older = i_valid[1] ? 2'd1 : 2'd2;

    // With a single grant, older and younger name the same source.
    o_younger = 2'd0;
    if (o_grant[2])      o_younger = 2'd2;
    else if (o_grant[1]) o_younger = 2'd1;
  end

endmodule

// File: rtl/zap_regf_write_scheduler.sv
// Maps up to two of three writeback requests per cycle onto register-file ports
// A/B, and zeroes the register file pairwise after reset.
module zap_regf_write_scheduler
  import zap_regf_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [2:0]          i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr0,
  input  logic [ADDR_W-1:0]   i_req_addr1,
  input  logic [ADDR_W-1:0]   i_req_addr2,
  input  logic [DATA_W-1:0]   i_req_data0,
  input  logic [DATA_W-1:0]   i_req_data1,
  input  logic [DATA_W-1:0]   i_req_data2,
  output logic [2:0]          o_req_ready,
  output logic                o_busy,
  output logic                o_wen,
  output logic [ADDR_W-1:0]   o_wr_addr_a,
  output logic [ADDR_W-1:0]   o_wr_addr_b,
  output logic [DATA_W-1:0]   o_wr_data_a,
  output logic [DATA_W-1:0]   o_wr_data_b
);

  state_t              r_state, w_state_next;
  logic [PAIR_W-1:0]   r_pair, w_pair_next;
  logic                r_busy, w_busy_next;
  logic                r_wen, w_wen_next;
  logic [ADDR_W-1:0]   r_addr_a, w_addr_a_next;
  logic [ADDR_W-1:0]   r_addr_b, w_addr_b_next;
  logic [DATA_W-1:0]   r_data_a, w_data_a_next;
  logic [DATA_W-1:0]   r_data_b, w_data_b_next;

  logic [ADDR_W-1:0]   w_addr [3];
  logic [DATA_W-1:0]   w_data [3];
  logic [2:0]          w_grant;
  logic [1:0]          w_older, w_younger;

  assign w_addr[0] = i_req_addr0;
  assign w_addr[1] = i_req_addr1;
  assign w_addr[2] = i_req_addr2;
  assign w_data[0] = i_req_data0;
  assign w_data[1] = i_req_data1;
  assign w_data[2] = i_req_data2;

  zap_regf_pick2 u_pick2 (
    .i_valid   (i_req_valid),
    .o_grant   (w_grant),
    .o_older   (w_older),
    .o_younger (w_younger)
  );

  assign o_req_ready = (r_state == RUN && !i_reset) ? w_grant : 3'b000;

  always_comb begin
    w_state_next  = r_state;
    w_pair_next   = r_pair;
    w_busy_next   = r_busy;
    w_wen_next    = 1'b0;
    // Idle cycles re-present the old addresses so the copy-select bits do not flip.
    w_addr_a_next = r_addr_a;
    w_addr_b_next = r_addr_b;
    w_data_a_next = r_data_a;
    w_data_b_next = r_data_b;

    if (r_state == CLEAR) begin
      w_wen_next    = 1'b1;
      w_addr_a_next = pair_addr(r_pair, 1'b0);
      w_addr_b_next = pair_addr(r_pair, 1'b1);
      w_data_a_next = '0;
      w_data_b_next = '0;
      if (r_pair == LAST_PAIR) begin
        w_state_next = RUN;
        w_busy_next  = 1'b0;
        w_pair_next  = '0;
      end else begin
        w_pair_next = r_pair + PAIR_W'(1);
      end
    end else if (|w_grant) begin
      w_wen_next    = 1'b1;
      w_addr_a_next = w_addr[w_older];
      w_addr_b_next = w_addr[w_younger];
      w_data_b_next = w_data[w_younger];
      // On a collision the younger write owns both ports; the older one is dropped.
      w_data_a_next = (w_addr[w_older] == w_addr[w_younger]) ? w_data[w_younger]
                                                              : w_data[w_older];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= CLEAR;
      r_pair   <= '0;
      r_busy   <= 1'b1;
      r_wen    <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= ADDR_W'(1);
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pair   <= w_pair_next;
      r_busy   <= w_busy_next;
      r_wen    <= w_wen_next;
      r_addr_a <= w_addr_a_next;
      r_addr_b <= w_addr_b_next;
      r_data_a <= w_data_a_next;
      r_data_b <= w_data_b_next;
    end
  end

  assign o_busy      = r_busy;
  assign o_wen       = r_wen;
  assign o_wr_addr_a = r_addr_a;
  assign o_wr_addr_b = r_addr_b;
  assign o_wr_data_a = r_data_a;
  assign o_wr_data_b = r_data_b;

  // Simulation-only check: sources must never present an out-of-range register.
  for (genvar gi = 0; gi < 3; gi++) begin : g_addr_chk
    a_addr_range: assert property (@(posedge i_clk) disable iff (i_reset)
                                   o_req_ready[gi] |-> (w_addr[gi] <= LAST_ADDR));
  end

endmodule

// File: tb/tb_zap_regf_write_scheduler.sv
// Randomized and directed checks of the write scheduler against a queue-based
// reference model plus a behavioural register file fed by the DUT ports.
module tb_zap_regf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  valid;
  logic [5:0]  t_addr [3];
  logic [31:0] t_data [3];
  logic [2:0]  o_req_ready;
  logic        o_busy, o_wen;
  logic [5:0]  o_wr_addr_a, o_wr_addr_b;
  logic [31:0] o_wr_data_a, o_wr_data_b;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model of the registered outputs and the clear progress.
  logic        m_run, m_busy, m_wen;
  int          m_k;
  logic [5:0]  m_a, m_b;
  logic [31:0] m_da, m_db;
  logic [31:0] exp_rf [64];
  logic [31:0] rf [64];

  always #5 clk = ~clk;

  zap_regf_write_scheduler dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (valid),
    .i_req_addr0 (t_addr[0]),
    .i_req_addr1 (t_addr[1]),
    .i_req_addr2 (t_addr[2]),
    .i_req_data0 (t_data[0]),
    .i_req_data1 (t_data[1]),
    .i_req_data2 (t_data[2]),
    .o_req_ready (o_req_ready),
    .o_busy      (o_busy),
    .o_wen       (o_wen),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b),
    .o_wr_data_a (o_wr_data_a),
    .o_wr_data_b (o_wr_data_b)
  );

  // Register file behaviour: port B wins on a same-address write.
  always @(posedge clk) begin
    if (o_wen) begin
      rf[o_wr_addr_a] <= o_wr_data_a;
      rf[o_wr_addr_b] <= o_wr_data_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict ready and next outputs from the current inputs, then check.
  task automatic step(output logic [2:0] granted);
    int g[$];
    logic [2:0] er;
    int o, y;
    @(negedge clk);
    er = 3'b000;
    if (rst) begin
      m_run = 1'b0; m_k = 0; m_busy = 1'b1; m_wen = 1'b0;
      m_a = 6'd0; m_b = 6'd1; m_da = 32'd0; m_db = 32'd0;
    end else if (!m_run) begin
      m_wen = 1'b1; m_a = 6'(2 * m_k); m_b = 6'(2 * m_k + 1); m_da = 32'd0; m_db = 32'd0;
      if (m_k == 19) begin m_run = 1'b1; m_busy = 1'b0; end
      else m_k++;
    end else begin
      for (int s = 0; s < 3; s++) if (valid[s] && g.size() < 2) g.push_back(s);
      foreach (g[i]) er[g[i]] = 1'b1;
      if (g.size() == 0) m_wen = 1'b0;
      else begin
        o = g[0]; y = g[g.size()-1];
        m_wen = 1'b1; m_a = t_addr[o]; m_b = t_addr[y]; m_db = t_data[y];
        m_da = (t_addr[o] == t_addr[y]) ? t_data[y] : t_data[o];
      end
    end
    if (m_wen) begin exp_rf[m_a] = m_da; exp_rf[m_b] = m_db; end
    chk("ready", 32'(o_req_ready), 32'(er));
    granted = er;
    @(posedge clk);
    #1;
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("wen", 32'(o_wen), 32'(m_wen));
    chk("addr_a", 32'(o_wr_addr_a), 32'(m_a));
    chk("addr_b", 32'(o_wr_addr_b), 32'(m_b));
    chk("data_a", o_wr_data_a, m_da);
    chk("data_b", o_wr_data_b, m_db);
    $display("t=%0t rst=%0b valid=%b ready=%b busy=%0b wen=%0b A=(%0d,%h) B=(%0d,%h)",
             $time, rst, valid, o_req_ready, o_busy, o_wen,
             o_wr_addr_a, o_wr_data_a, o_wr_addr_b, o_wr_data_b);
  endtask

  task automatic idle(input int n);
    logic [2:0] g;
    valid = 3'b000;
    for (int i = 0; i < n; i++) step(g);
  endtask

  task automatic req(input int s, input logic [5:0] a, input logic [31:0] d);
    valid[s] = 1'b1; t_addr[s] = a; t_data[s] = d;
  endtask

  initial begin
    logic [2:0] g;
    rst = 1'b1; valid = 3'b000;
    for (int s = 0; s < 3; s++) begin t_addr[s] = '0; t_data[s] = '0; end
    for (int i = 0; i < 64; i++) exp_rf[i] = 32'd0;
    idle(3);

    // Clear sequence: requests are asserted but must not be granted while busy.
    rst = 1'b0;
    req(0, 6'd1, 32'h1); req(1, 6'd2, 32'h2); req(2, 6'd3, 32'h3);
    for (int i = 0; i < 20; i++) step(g);
    chk("busy_after_clear", 32'(o_busy), 32'd0);
    step(g);   // first RUN cycle: sources 0,1 granted
    valid = valid & ~g;
    step(g);   // source 2 drains
    idle(1);

    // Single write from source 1.
    req(1, 6'd5, 32'hDEAD_BEEF); step(g);
    chk("single_a", 32'(o_wr_addr_a), 32'd5);
    idle(1);
    chk("rd_r5", rf[5], 32'hDEAD_BEEF);

    // Dual write from sources 0 and 2.
    req(0, 6'd3, 32'h11); req(2, 6'd7, 32'h22); step(g);
    idle(1);
    chk("rd_r3", rf[3], 32'h11);
    chk("rd_r7", rf[7], 32'h22);

    // Collision on r9: younger data on both ports.
    req(0, 6'd9, 32'hAA); req(1, 6'd9, 32'hBB); step(g);
    chk("coll_da", o_wr_data_a, 32'hBB);
    idle(1);
    chk("rd_r9", rf[9], 32'hBB);

    // Overload: source 2 held then granted alone.
    req(0, 6'd10, 32'h100); req(1, 6'd11, 32'h101); req(2, 6'd12, 32'h102);
    step(g);
    valid = valid & ~g;
    step(g);
    idle(1);
    chk("rd_r12", rf[12], 32'h102);

    // Idle coherency, then reset in the middle of idle.
    req(0, 6'd2, 32'h202); req(1, 6'd4, 32'h404); step(g);
    idle(10);
    chk("idle_a", 32'(o_wr_addr_a), 32'd2);
    chk("idle_b", 32'(o_wr_addr_b), 32'd4);
    chk("rd_r2", rf[2], 32'h202);
    chk("rd_r4", rf[4], 32'h404);
    rst = 1'b1; idle(1);
    rst = 1'b0; idle(20);

    // Randomized traffic with held requests and one mid-run reset.
    valid = 3'b000;
    for (int it = 0; it < 400; it++) begin
      for (int s = 0; s < 3; s++)
        if (!valid[s] && $urandom_range(0, 99) < 55)
          req(s, 6'($urandom_range(0, 39)), $urandom);
      rst = (it == 200);
      step(g);
      if (rst) valid = 3'b000;
      else valid = valid & ~g;
    end
    rst = 1'b0;
    idle(2);
    for (int r = 0; r < 40; r++) chk($sformatf("rf[%0d]", r), rf[r], exp_rf[r]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
